alu_sched: RTL and testbench
============================

# alu_sched

Round-robin scheduler that shares the single registered ALU among `NUM_REQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives the ALU's `exec`/`oper`/`A`/`B` inputs for exactly one cycle. It captures `res_out` and returns the result with the requester ID and an error flag over a valid/ready response channel. It sits between the memory-side command sources and the ALU instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `DATA_WIDTH`, 8, operand width; results are `2*DATA_WIDTH` bits.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester ID (derived; do not override).

- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester command valid.
- `req_ready`  out  `NUM_REQ`  per-requester grant; one-hot or zero.
- `req_oper`  in  `NUM_REQ`x3  per-requester opcode.
- `req_a`, `req_b`  in  `NUM_REQ`x`DATA_WIDTH`  per-requester operands.
- `alu_exec`  out  1  ALU execute strobe.
- `alu_oper`  out  3  ALU opcode.
- `alu_a`, `alu_b`  out  `DATA_WIDTH`  ALU operands.
- `alu_res`  in  `2*DATA_WIDTH`  ALU registered result.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  `ID_W`  index of the requester that issued the command.
- `resp_data`  out  `2*DATA_WIDTH`  result.
- `resp_err`  out  1  set for divide-by-zero or an illegal opcode.

## Operation
- ALU opcodes:
  - 0: clear, result 0.
  - 1: add.
  - 2: subtract.
  - 3: multiply.
  - 4: divide; returns `ERROR_CODE` 16'hDEAD when B = 0.
  - 5–7: illegal.
- FSM states:
  - IDLE: the arbiter presents a one-hot `req_ready` to the highest-priority valid requester. On the handshake, latch oper/A/B/ID and move to EXEC. If the opcode is illegal, move to RESP instead.
  - EXEC: `alu_exec`=1 for exactly one cycle with the latched oper/A/B → CAPT.
  - CAPT: register `alu_res` into `resp_data`. Set `resp_err` = (oper==4 && B==0) → RESP.
  - RESP: hold `resp_valid`=1 and all response fields stable until `resp_ready` → IDLE.
- Illegal opcode: the ALU is not touched (`alu_exec` stays 0). The response is `resp_data`=0, `resp_err`=1.
- Divide by zero: the operation is issued normally. `resp_data` = 16'hDEAD, zero-extended or truncated to `2*DATA_WIDTH`. `resp_err`=1.
- Round-robin arbitration:
  - The priority pointer starts at 0.
  - After each grant to index g, the pointer becomes (g+1) mod `NUM_REQ`.
  - The pointer does not move when there is no grant.
- `req_ready` is 0 in every state other than IDLE. A requester's valid may be held across non-IDLE cycles without loss.
- `alu_oper`/`alu_a`/`alu_b` show the latched values in every state. They are only meaningful while `alu_exec`=1.
- Wide subtract results are passed through from the ALU unchanged; the scheduler does no arithmetic on them.

## Timing
- Reset values: FSM=IDLE, pointer=0, `req_ready`=0 during reset, `alu_exec`=0, `alu_oper`/`alu_a`/`alu_b`=0, `resp_valid`=0, `resp_id`/`resp_data`/`resp_err`=0.
- Legal op: handshake at edge t → `alu_exec` high in cycle t+1 → capture in cycle t+2 → `resp_valid` from cycle t+3.
- Illegal op: `resp_valid` from cycle t+1.
- Peak throughput is one op per 4 cycles, because `resp_ready` must be high in the first RESP cycle and IDLE follows.
- The next grant happens no earlier than the cycle after the response handshake. IDLE and RESP never overlap.
- Reset asserted mid-operation aborts the transaction with no response. `alu_exec` is low from the next edge. The ALU is expected to be reset by the same `reset`.
- `resp_ready` held low: RESP is held indefinitely and all `req_ready` stay 0.

## Structure
- Package `alu_pkg` holds:
  - the `alu_op_e` enum (CLR, ADD, SUB, MUL, DIV);
  - `ERROR_CODE` = 16'hDEAD;
  - the `sched_state_e` enum (IDLE, EXEC, CAPT, RESP);
  - the helper function `is_legal_op`.
- Sub-module `rr_arbiter`, parameterised on `NUM_REQ`:
  - inputs: request vector, `advance` strobe;
  - outputs: one-hot grant, grant index;
  - contains the pointer register and uses the same synchronous reset.

## Test plan
- Single op: requester 2 issues ADD A=200, B=100 with `resp_ready`=1. Expect `alu_exec` one cycle at t+1, then `resp_valid` at t+3 with `resp_id`=2, `resp_data`=300, `resp_err`=0.
- Divide and illegal opcode:
  - DIV A=9, B=0 → `resp_data`=0xDEAD, `resp_err`=1.
  - Opcode 6 → no `alu_exec` pulse; `resp_data`=0 and `resp_err`=1 at t+1.
- Fairness: all 4 requesters hold valid continuously. Expect grant order 0,1,2,3,0,… and exactly one `req_ready` per grant.
- Backpressure: MUL 15×17 with `resp_ready`=0 for 10 cycles. Expect `resp_data`=255 held stable, all `req_ready`=0, no `alu_exec` pulse, then release on the handshake.
- Reset mid-op: assert `reset` in the EXEC cycle. Expect no response, all outputs at their reset values, and pointer=0. The next request from requester 3 is served normally.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_pkg: shared types and constants for the ALU scheduler slice.
// Holds the ALU opcode enum, the divide-by-zero result code, the scheduler
// FSM state enum and the opcode legality helper used when a command is taken.
package alu_pkg;

  typedef enum logic [2:0] {
    CLR = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    MUL = 3'd3,
    DIV = 3'd4
  } alu_op_e;

  localparam logic [15:0] ERROR_CODE = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } sched_state_e;

  // Opcodes 5..7 have no ALU meaning and must never reach the ALU.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= DIV);
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: bundles the requester command channels, the ALU drive/result
// signals and the response channel of the scheduler.
//   slave  : scheduler view (takes commands, drives ALU, returns responses)
//   master : environment view (command sources, ALU result, response sink)
interface alu_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][2:0]            req_oper;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;

  logic                               alu_exec;
  logic [2:0]                         alu_oper;
  logic [DATA_WIDTH-1:0]              alu_a;
  logic [DATA_WIDTH-1:0]              alu_b;
  logic [2*DATA_WIDTH-1:0]            alu_res;

  logic                               resp_valid;
  logic                               resp_ready;
  logic [ID_W-1:0]                    resp_id;
  logic [2*DATA_WIDTH-1:0]            resp_data;
  logic                               resp_err;

  modport slave (
    input  req_valid, req_oper, req_a, req_b, alu_res, resp_ready,
    output req_ready, alu_exec, alu_oper, alu_a, alu_b,
           resp_valid, resp_id, resp_data, resp_err
  );

  modport master (
    output req_valid, req_oper, req_a, req_b, alu_res, resp_ready,
    input  req_ready, alu_exec, alu_oper, alu_a, alu_b,
           resp_valid, resp_id, resp_data, resp_err
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clk, reset : clock and synchronous active-high reset
//   req        : request vector
//   advance    : grant was accepted; pointer moves past the granted index
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted requester
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  int              idx;
  logic            found;

  // Scan from the pointer upward with wraparound; the first active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer only moves on an accepted grant, to the slot after the winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one registered ALU among NUM_REQ requesters.
// Takes one command at a time (round-robin), pulses alu_exec for one cycle,
// captures the ALU result and returns it with requester ID and error flag.
//   clk, reset : clock and synchronous active-high reset
//   bus        : alu_sched_if slave modport (commands, ALU drive, response)
module alu_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic        clk,
  input logic        reset,
  alu_sched_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int RES_W = 2 * DATA_WIDTH;
  localparam logic [RES_W-1:0] ERR_DATA = RES_W'(ERROR_CODE);

  sched_state_e          state;
  sched_state_e          state_next;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  handshake;
  logic                  div_by_zero;

  logic [2:0]            lat_oper;
  logic [DATA_WIDTH-1:0] lat_a;
  logic [DATA_WIDTH-1:0] lat_b;
  logic [ID_W-1:0]       resp_id_q;
  logic [RES_W-1:0]      resp_data_q;
  logic                  resp_err_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign handshake   = |(bus.req_valid & bus.req_ready);
  assign div_by_zero = (lat_oper == DIV) && (lat_b == '0);

  assign bus.alu_oper  = lat_oper;
  assign bus.alu_a     = lat_a;
  assign bus.alu_b     = lat_b;
  assign bus.resp_id   = resp_id_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_err  = resp_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: illegal opcodes skip the ALU and go straight to the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (handshake)
              state_next = is_legal_op(bus.req_oper[grant_idx]) ? EXEC : RESP;
      EXEC: state_next = CAPT;
      CAPT: state_next = RESP;
      RESP: if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded strobes; req_ready is also held low while reset is asserted.
  always_comb begin
    bus.req_ready  = '0;
    bus.alu_exec   = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: if (!reset) bus.req_ready = grant;
      EXEC: bus.alu_exec = 1'b1;
      RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Command latch and response capture. An illegal opcode sets its response
  // at the handshake since no ALU result will ever come back for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_oper    <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (state == IDLE && handshake) begin
        lat_oper  <= bus.req_oper[grant_idx];
        lat_a     <= bus.req_a[grant_idx];
        lat_b     <= bus.req_b[grant_idx];
        resp_id_q <= grant_idx;
        if (!is_legal_op(bus.req_oper[grant_idx])) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if (state == CAPT) begin
        resp_data_q <= div_by_zero ? ERR_DATA : bus.alu_res;
        resp_err_q  <= div_by_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: self-checking bench for alu_sched with a behavioural ALU,
// a transaction-level reference model (rotating pointer + arithmetic rules)
// and directed plus randomized command streams.
module tb_alu_sched;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  alu_sched_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  alu_sched #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int modelPtr   = 0;

  logic [N-1:0] validMask;
  logic [2:0]   cmdOp [N];
  logic [7:0]   cmdA  [N];
  logic [7:0]   cmdB  [N];

  // Arithmetic rules of the shared ALU, 16-bit results.
  function automatic logic [15:0] refResult(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    case (op)
      3'd0: return 16'd0;
      3'd1: return 16'(a) + 16'(b);
      3'd2: return 16'(a) - 16'(b);
      3'd3: return 16'(a) * 16'(b);
      3'd4: return (b == 8'd0) ? 16'hDEAD : 16'(a) / 16'(b);
      default: return 16'd0;
    endcase
  endfunction

  function automatic int pickGrant(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++)
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Behavioural registered ALU, reset with the scheduler.
  always @(posedge clk) begin
    if (reset) bus.alu_res <= '0;
    else if (bus.alu_exec) bus.alu_res <= refResult(bus.alu_oper, bus.alu_a, bus.alu_b);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = validMask[i];
      bus.req_oper[i]  = cmdOp[i];
      bus.req_a[i]     = cmdA[i];
      bus.req_b[i]     = cmdB[i];
    end
  endtask

  task automatic randomCmd(input int i);
    cmdOp[i] = 3'($urandom_range(0, 7));
    cmdA[i]  = 8'($urandom);
    cmdB[i]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
  endtask

  task automatic setCmd(input int i, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    cmdOp[i] = op;
    cmdA[i]  = a;
    cmdB[i]  = b;
  endtask

  // Called just after a rising edge with the DUT in IDLE: checks one grant,
  // the execute/capture timing, the response and holdCycles of backpressure.
  task automatic serveOne(input bit keepValid, input int holdCycles);
    int          g;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] expData;
    logic        expErr;
    logic [N-1:0] expGrant;
    g = pickGrant(validMask, modelPtr);
    if (g < 0) return;
    op = cmdOp[g];
    a  = cmdA[g];
    b  = cmdB[g];
    expData  = refResult(op, a, b);
    expErr   = (op > 3'd4) || (op == 3'd4 && b == 8'd0);
    expGrant = '0;
    expGrant[g] = 1'b1;

    @(negedge clk);
    checkOutput("grant", bus.req_ready, expGrant);
    @(posedge clk);
    #1;
    modelPtr = (g + 1) % N;
    if (keepValid) randomCmd(g);
    else validMask[g] = 1'b0;
    applyStimulus();

    if (op <= 3'd4) begin
      @(negedge clk);
      checkOutput("exec_on", bus.alu_exec, 1);
      checkOutput("alu_oper", bus.alu_oper, op);
      checkOutput("alu_ab", {bus.alu_a, bus.alu_b}, {a, b});
      @(negedge clk);
      checkOutput("exec_once", bus.alu_exec, 0);
      checkOutput("ready_busy", bus.req_ready, 0);
      checkOutput("resp_early", bus.resp_valid, 0);
      @(negedge clk);
    end else begin
      @(negedge clk);
      checkOutput("illegal_noexec", bus.alu_exec, 0);
    end
    checkOutput("resp_valid", bus.resp_valid, 1);
    checkOutput("resp_id", bus.resp_id, g);
    checkOutput("resp_data", bus.resp_data, expData);
    checkOutput("resp_err", bus.resp_err, expErr);

    for (int k = 0; k < holdCycles; k++) begin
      @(negedge clk);
      checkOutput("hold_valid", bus.resp_valid, 1);
      checkOutput("hold_data", {bus.resp_err, bus.resp_data}, {expErr, expData});
      checkOutput("hold_ready", bus.req_ready, 0);
      checkOutput("hold_exec", bus.alu_exec, 0);
    end

    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    checkOutput("resp_released", bus.resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < N; i++) setCmd(i, 3'd1, 8'd0, 8'd0);
    validMask = 4'b0001;
    applyStimulus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_exec", bus.alu_exec, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_alu_in", {bus.alu_oper, bus.alu_a, bus.alu_b}, 0);
    checkOutput("rst_resp", {bus.resp_id, bus.resp_err, bus.resp_data}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    validMask = '0;
    applyStimulus();

    // Directed: add, divide by zero, illegal opcode, backpressured multiply.
    setCmd(2, 3'd1, 8'd200, 8'd100); validMask = 4'b0100; applyStimulus(); serveOne(0, 0);
    setCmd(0, 3'd4, 8'd9, 8'd0);     validMask = 4'b0001; applyStimulus(); serveOne(0, 0);
    setCmd(1, 3'd6, 8'd3, 8'd4);     validMask = 4'b0010; applyStimulus(); serveOne(0, 0);
    setCmd(3, 3'd3, 8'd15, 8'd17);   validMask = 4'b1000; applyStimulus(); serveOne(0, 10);

    // Fairness: everyone requests continuously.
    for (int i = 0; i < N; i++) randomCmd(i);
    validMask = '1;
    applyStimulus();
    repeat (8) serveOne(1, 0);

    // Reset during the execute cycle aborts with no response.
    validMask = '0;
    setCmd(1, 3'd1, 8'd5, 8'd6);
    validMask = 4'b0010;
    applyStimulus();
    @(negedge clk);
    checkOutput("midrst_grant", bus.req_ready, 4'b0010);
    @(posedge clk);
    #1;
    validMask = '0;
    applyStimulus();
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_exec", bus.alu_exec, 0);
    checkOutput("midrst_alu_in", {bus.alu_oper, bus.alu_a, bus.alu_b}, 0);
    checkOutput("midrst_resp", {bus.resp_valid, bus.resp_id, bus.resp_err, bus.resp_data}, 0);
    reset = 1'b0;
    modelPtr = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_noresp", bus.resp_valid, 0);
    end
    @(posedge clk);
    #1;
    setCmd(1, 3'd2, 8'd10, 8'd30);
    setCmd(3, 3'd1, 8'd7, 8'd8);
    validMask = 4'b1010;
    applyStimulus();
    serveOne(0, 0);
    serveOne(0, 0);

    // Randomized masks, opcodes and backpressure.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        randomCmd(i);
        validMask[i] = 1'($urandom_range(0, 1));
      end
      if (validMask == '0) validMask[$urandom_range(0, N - 1)] = 1'b1;
      applyStimulus();
      serveOne(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
